tcam_lookup_responder: RTL and testbench

TCAM_LOOKUP_RESPONDER -- requirements
Module: tcam_lookup_responder

---
 rtl/tcam_lookup_responder_pkg.sv | 20 ++
 rtl/tcam_lookup_responder_entry_array.sv | 65 ++++++
 rtl/tcam_lookup_responder.sv | 171 +++++++++++++++++
 tb/tb_tcam_lookup_responder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tcam_lookup_responder_pkg.sv
// ---------------------------------------------------------------------------
// tcam_lookup_responder_pkg
// Shared definitions for the TCAM lookup responder and the packet dispatcher:
// FSM state encoding and the default table geometry.
// ---------------------------------------------------------------------------
package tcam_lookup_responder_pkg;

   localparam int STATE_WIDTH         = 2;
   localparam int DEFAULT_KEY_WIDTH   = 192;
   localparam int DEFAULT_DEST_WIDTH  = 3;
   localparam int DEFAULT_ENTRY_COUNT = 8;

   typedef enum logic [STATE_WIDTH-1:0] {
      ST_INIT    = 2'd0,
      ST_IDLE    = 2'd1,
      ST_SEARCH  = 2'd2,
      ST_RESPOND = 2'd3
   } state_t;

endpackage

// File: rtl/tcam_lookup_responder_entry_array.sv
// ---------------------------------------------------------------------------
// tcam_entry_array
// Entry storage (key, care-mask, destination, valid) plus one indexed
// read-compare port. Storage has no reset; the owner clears it entry by
// entry through the clear port.
//
// Ports:
//   clk                      clock
//   clr_en / clr_index       zero one entry (takes priority over write)
//   wr_en / wr_index         write one entry with wr_key/wr_mask/wr_dest/wr_valid
//   rd_index / rd_key        entry to compare and key to compare against
//   hit / hit_dest           registered compare result for the rd_index
//                            presented one cycle earlier
// ---------------------------------------------------------------------------
module tcam_entry_array
   import tcam_lookup_responder_pkg::*;
#(
   parameter int KEY_WIDTH   = DEFAULT_KEY_WIDTH,
   parameter int DEST_WIDTH  = DEFAULT_DEST_WIDTH,
   parameter int ENTRY_COUNT = DEFAULT_ENTRY_COUNT,
   localparam int INDEX_WIDTH = $clog2(ENTRY_COUNT)
) (
   input  logic                   clk,
   input  logic                   clr_en,
   input  logic [INDEX_WIDTH-1:0] clr_index,
   input  logic                   wr_en,
   input  logic [INDEX_WIDTH-1:0] wr_index,
   input  logic [KEY_WIDTH-1:0]   wr_key,
   input  logic [KEY_WIDTH-1:0]   wr_mask,
   input  logic [DEST_WIDTH-1:0]  wr_dest,
   input  logic                   wr_valid,
   input  logic [INDEX_WIDTH-1:0] rd_index,
   input  logic [KEY_WIDTH-1:0]   rd_key,
   output logic                   hit,
   output logic [DEST_WIDTH-1:0]  hit_dest
);

   logic [KEY_WIDTH-1:0]  ent_key   [ENTRY_COUNT];
   logic [KEY_WIDTH-1:0]  ent_mask  [ENTRY_COUNT];
   logic [DEST_WIDTH-1:0] ent_dest  [ENTRY_COUNT];
   logic                  ent_valid [ENTRY_COUNT];

   always_ff @(posedge clk) begin
      if (clr_en) begin
         ent_key[clr_index]   <= '0;
         ent_mask[clr_index]  <= '0;
         ent_dest[clr_index]  <= '0;
         ent_valid[clr_index] <= 1'b0;
      end else if (wr_en) begin
         ent_key[wr_index]   <= wr_key;
         ent_mask[wr_index]  <= wr_mask;
         ent_dest[wr_index]  <= wr_dest;
         ent_valid[wr_index] <= wr_valid;
      end
   end

   // Only bits with mask=1 take part in the compare, so a zero mask on a
   // valid entry matches every key.
   always_ff @(posedge clk) begin
      hit      <= ent_valid[rd_index] &&
                  (((rd_key ^ ent_key[rd_index]) & ent_mask[rd_index]) == '0);
      hit_dest <= ent_dest[rd_index];
   end

endmodule

// File: rtl/tcam_lookup_responder.sv
// ---------------------------------------------------------------------------
// tcam_lookup_responder
// Sequential TCAM: clears the table after reset, then accepts entry writes
// and key lookups. A lookup scans entries from index 0 upward, one per cycle;
// the lowest-index match wins. The result is a one-cycle pulse.
//
// Handshake: a request (req_valid/req_ready) or write (wr_en/wr_ready) is
// accepted on the rising edge where both signals are high. Ready is high only
// in IDLE. res_valid has no backpressure. A write and a request accepted on
// the same edge are both taken and the lookup sees the new entry.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready/req_key       lookup request
//   res_valid/res_null/res_data       lookup result (res_null = miss)
//   wr_en/wr_ready/wr_index/wr_key/wr_mask/wr_dest/wr_entry_valid
//                                     entry write
//   end_init_tcam            high once the post-reset clear has finished
//   rst_miss_counter         synchronous clear of reg_miss_counter
//   reg_miss_counter         number of lookups that missed (wraps)
//   dbg_state                current FSM state
// ---------------------------------------------------------------------------
module tcam_lookup_responder
   import tcam_lookup_responder_pkg::*;
#(
   parameter int KEY_WIDTH   = DEFAULT_KEY_WIDTH,
   parameter int DEST_WIDTH  = DEFAULT_DEST_WIDTH,
   parameter int ENTRY_COUNT = DEFAULT_ENTRY_COUNT,
   localparam int INDEX_WIDTH = $clog2(ENTRY_COUNT)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [KEY_WIDTH-1:0]   req_key,
   output logic                   res_valid,
   output logic                   res_null,
   output logic [DEST_WIDTH-1:0]  res_data,
   input  logic                   wr_en,
   output logic                   wr_ready,
   input  logic [INDEX_WIDTH-1:0] wr_index,
   input  logic [KEY_WIDTH-1:0]   wr_key,
   input  logic [KEY_WIDTH-1:0]   wr_mask,
   input  logic [DEST_WIDTH-1:0]  wr_dest,
   input  logic                   wr_entry_valid,
   output logic                   end_init_tcam,
   input  logic                   rst_miss_counter,
   output logic [31:0]            reg_miss_counter,
   output logic [STATE_WIDTH-1:0] dbg_state
);

   localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(ENTRY_COUNT - 1);

   state_t                 state;
   logic [INDEX_WIDTH-1:0] clr_idx;
   logic [INDEX_WIDTH-1:0] search_idx;  // entry being read this cycle
   logic [INDEX_WIDTH-1:0] check_idx;   // entry whose result is in hit/hit_dest
   logic                   check_valid; // hit/hit_dest belong to this lookup
   logic [KEY_WIDTH-1:0]   key_q;

   logic                   hit;
   logic [DEST_WIDTH-1:0]  hit_dest;
   logic                   wr_accept;
   logic                   miss_evt;

   assign dbg_state = state;
   assign wr_accept = wr_en && wr_ready;
   assign miss_evt  = (state == ST_SEARCH) && check_valid && !hit &&
                      (check_idx == LAST_IDX);

   tcam_entry_array #(
      .KEY_WIDTH   (KEY_WIDTH),
      .DEST_WIDTH  (DEST_WIDTH),
      .ENTRY_COUNT (ENTRY_COUNT)
   ) u_entry_array (
      .clk       (clk),
      .clr_en    (state == ST_INIT),
      .clr_index (clr_idx),
      .wr_en     (wr_accept),
      .wr_index  (wr_index),
      .wr_key    (wr_key),
      .wr_mask   (wr_mask),
      .wr_dest   (wr_dest),
      .wr_valid  (wr_entry_valid),
      .rd_index  (search_idx),
      .rd_key    (key_q),
      .hit       (hit),
      .hit_dest  (hit_dest)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= ST_INIT;
         clr_idx          <= '0;
         search_idx       <= '0;
         check_idx        <= '0;
         check_valid      <= 1'b0;
         key_q            <= '0;
         end_init_tcam    <= 1'b0;
         req_ready        <= 1'b0;
         wr_ready         <= 1'b0;
         res_valid        <= 1'b0;
         res_null         <= 1'b0;
         res_data         <= '0;
         reg_miss_counter <= '0;
      end else begin
         // Clear wins over an increment on the same edge.
         if (rst_miss_counter)
            reg_miss_counter <= '0;
         else if (miss_evt)
            reg_miss_counter <= reg_miss_counter + 32'd1;

         // Result outputs are pulses; they are only set on entry to RESPOND.
         res_valid <= 1'b0;
         res_null  <= 1'b0;
         res_data  <= '0;

         case (state)
            ST_INIT: begin
               if (clr_idx == LAST_IDX) begin
                  state         <= ST_IDLE;
                  end_init_tcam <= 1'b1;
                  req_ready     <= 1'b1;
                  wr_ready      <= 1'b1;
               end else begin
                  clr_idx <= clr_idx + INDEX_WIDTH'(1);
               end
            end

            ST_IDLE: begin
               if (req_valid) begin
                  key_q       <= req_key;
                  search_idx  <= '0;
                  check_valid <= 1'b0;
                  req_ready   <= 1'b0;
                  wr_ready    <= 1'b0;
                  state       <= ST_SEARCH;
               end
            end

            // The array compare is registered, so each cycle we issue
            // search_idx and judge the result of check_idx (issued one
            // cycle earlier).
            ST_SEARCH: begin
               if (check_valid && hit) begin
                  res_valid <= 1'b1;
                  res_data  <= hit_dest;
                  state     <= ST_RESPOND;
               end else if (miss_evt) begin
                  res_valid <= 1'b1;
                  res_null  <= 1'b1;
                  state     <= ST_RESPOND;
               end else begin
                  check_valid <= 1'b1;
                  check_idx   <= search_idx;
                  search_idx  <= search_idx + INDEX_WIDTH'(1);
               end
            end

            ST_RESPOND: begin
               req_ready <= 1'b1;
               wr_ready  <= 1'b1;
               state     <= ST_IDLE;
            end

            default: state <= ST_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_tcam_lookup_responder.sv
// ---------------------------------------------------------------------------
// tb_tcam_lookup_responder
// Directed test of the TCAM lookup responder with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_tcam_lookup_responder;
   import tcam_lookup_responder_pkg::*;

   localparam int KW = 192;
   localparam int DW = 3;
   localparam int EC = 8;
   localparam int IW = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic                   req_valid;
   logic                   req_ready;
   logic [KW-1:0]          req_key;
   logic                   res_valid;
   logic                   res_null;
   logic [DW-1:0]          res_data;
   logic                   wr_en;
   logic                   wr_ready;
   logic [IW-1:0]          wr_index;
   logic [KW-1:0]          wr_key;
   logic [KW-1:0]          wr_mask;
   logic [DW-1:0]          wr_dest;
   logic                   wr_entry_valid;
   logic                   end_init_tcam;
   logic                   rst_miss_counter;
   logic [31:0]            reg_miss_counter;
   logic [STATE_WIDTH-1:0] dbg_state;

   tcam_lookup_responder #(
      .KEY_WIDTH   (KW),
      .DEST_WIDTH  (DW),
      .ENTRY_COUNT (EC)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_key          (req_key),
      .res_valid        (res_valid),
      .res_null         (res_null),
      .res_data         (res_data),
      .wr_en            (wr_en),
      .wr_ready         (wr_ready),
      .wr_index         (wr_index),
      .wr_key           (wr_key),
      .wr_mask          (wr_mask),
      .wr_dest          (wr_dest),
      .wr_entry_valid   (wr_entry_valid),
      .end_init_tcam    (end_init_tcam),
      .rst_miss_counter (rst_miss_counter),
      .reg_miss_counter (reg_miss_counter),
      .dbg_state        (dbg_state)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      req_valid        = 1'b0;
      req_key          = '0;
      wr_en            = 1'b0;
      wr_index         = '0;
      wr_key           = '0;
      wr_mask          = '0;
      wr_dest          = '0;
      wr_entry_valid   = 1'b0;
      rst_miss_counter = 1'b0;
   endtask

   // Called at a negedge right after rst is released: eight clearing
   // cycles with end_init_tcam low, then IDLE.
   task automatic check_init(input string tag);
      check({tag, " init_c1"}, end_init_tcam, 0);
      for (int i = 2; i <= 8; i++) begin
         @(posedge clk); #1;
         check({tag, " init_low"}, end_init_tcam, 0);
         check({tag, " init_rdy"}, req_ready, 0);
         check({tag, " init_resv"}, res_valid, 0);
      end
      @(posedge clk); #1;
      check({tag, " init_done"}, end_init_tcam, 1);
      check({tag, " req_ready"}, req_ready, 1);
      check({tag, " wr_ready"}, wr_ready, 1);
      check({tag, " state_idle"}, dbg_state, ST_IDLE);
   endtask

   task automatic do_write(input logic [IW-1:0] idx, input logic [KW-1:0] key,
                           input logic [KW-1:0] mask, input logic [DW-1:0] dest,
                           input logic v);
      @(negedge clk);
      check("wr_ready", wr_ready, 1);
      wr_en = 1'b1; wr_index = idx; wr_key = key; wr_mask = mask;
      wr_dest = dest; wr_entry_valid = v;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   // Acceptance edge is the next posedge; lat counts edges after it until
   // res_valid is seen.
   task automatic wait_result(input string tag, input int lat, input logic nul,
                              input logic [DW-1:0] data);
      int n;
      n = 0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      wr_en     = 1'b0;
      check({tag, " busy"}, req_ready, 0);
      do begin
         @(posedge clk); #1;
         n++;
      end while (!res_valid && n < 40);
      check({tag, " latency"}, n, lat);
      check({tag, " null"}, res_null, nul);
      check({tag, " data"}, res_data, data);
      @(posedge clk); #1;
      check({tag, " pulse"}, res_valid, 0);
      check({tag, " data_idle"}, res_data, 0);
      check({tag, " ready_back"}, req_ready, 1);
   endtask

   task automatic lookup(input string tag, input logic [KW-1:0] key, input int lat,
                         input logic nul, input logic [DW-1:0] data);
      @(negedge clk);
      check({tag, " ready"}, req_ready, 1);
      req_valid = 1'b1;
      req_key   = key;
      wait_result(tag, lat, nul, data);
   endtask

   // ---------------- stimulus ----------------
   logic [KW-1:0] all_ones;
   logic [KW-1:0] hi_key;

   initial begin
      all_ones = '1;
      hi_key   = (192'd1 << 150) | 192'hA5;
      idle_inputs();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst end_init", end_init_tcam, 0);
      check("rst req_ready", req_ready, 0);
      check("rst wr_ready", wr_ready, 0);
      check("rst res_valid", res_valid, 0);
      check("rst res_data", res_data, 0);
      check("rst miss_cnt", reg_miss_counter, 0);
      @(negedge clk);
      rst = 1'b0;
      check_init("boot");

      // Empty table: every lookup misses after a full scan
      lookup("empty_77", 192'h77, 9, 1'b1, 0);
      check("miss_cnt1", reg_miss_counter, 1);
      lookup("empty_12", 192'h12, 9, 1'b1, 0);
      check("miss_cnt2", reg_miss_counter, 2);
      @(negedge clk);
      rst_miss_counter = 1'b1;
      @(posedge clk); #1;
      rst_miss_counter = 1'b0;
      check("miss_clr", reg_miss_counter, 0);
      // Clear held across the miss edge must win over the increment
      rst_miss_counter = 1'b1;
      lookup("miss_ovr", 192'h33, 9, 1'b1, 0);
      rst_miss_counter = 1'b0;
      check("miss_ovr_cnt", reg_miss_counter, 0);

      // Single exact entry at index 3
      do_write(3'd3, 192'hA5, 192'hFF, 3'd5, 1'b1);
      lookup("hit_a5", 192'hA5, 5, 1'b0, 3'd5);
      lookup("hit_a5_hi", hi_key, 5, 1'b0, 3'd5);
      lookup("miss_a4", 192'hA4, 9, 1'b1, 0);
      check("miss_cnt3", reg_miss_counter, 1);

      // Wildcard at 1 and exact 0x10 at 4: lowest index wins
      do_write(3'd1, 192'hFF, 192'h0, 3'd2, 1'b1);
      do_write(3'd4, 192'h10, all_ones, 3'd6, 1'b1);
      lookup("prio_10", 192'h10, 3, 1'b0, 3'd2);
      // Disable the wildcard
      do_write(3'd1, 192'hFF, 192'h0, 3'd2, 1'b0);
      lookup("idx4_10", 192'h10, 6, 1'b0, 3'd6);
      lookup("idx3_a5", 192'hA5, 5, 1'b0, 3'd5);

      // Write and request accepted on the same edge
      @(negedge clk);
      check("both_wr_ready", wr_ready, 1);
      wr_en = 1'b1; wr_index = 3'd0; wr_key = 192'h3C; wr_mask = all_ones;
      wr_dest = 3'd1; wr_entry_valid = 1'b1;
      req_valid = 1'b1; req_key = 192'h3C;
      wait_result("same_cyc", 2, 1'b0, 3'd1);

      // Reset while searching index 4
      @(negedge clk);
      req_valid = 1'b1;
      req_key   = 192'h55;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort res_valid", res_valid, 0);
      check("abort end_init", end_init_tcam, 0);
      check("abort req_ready", req_ready, 0);
      check("abort miss_cnt", reg_miss_counter, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_init("reinit");
      lookup("post_3c", 192'h3C, 9, 1'b1, 0);
      lookup("post_a5", 192'hA5, 9, 1'b1, 0);
      check("post_miss_cnt", reg_miss_counter, 2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Hard time bound on the whole run
   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
